cpu_sequencer: RTL and testbench

//  Multi-cycle FSM that runs the core through FETCH/DECODE/EXEC/WB phases around the combinational control_unit.

---
 rtl/fib_pkg.sv | 32 +++
 rtl/seq_fetch_timer.sv | 30 +++
 rtl/cpu_sequencer.sv | 132 +++++++++++++
 tb/tb_cpu_sequencer.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared definitions for the multi-cycle sequencer and the control unit:
// FSM state encoding, fault codes and the opcodes the core executes.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_FAULT  = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ILLEGAL = 2'd1,
        FC_TIMEOUT = 2'd2
    } fault_code_t;

    localparam logic [6:0] OPCODE_I_TYPE = 7'h13;
    localparam logic [6:0] OPCODE_B_TYPE = 7'h63;
    localparam logic [6:0] OPCODE_R_TYPE = 7'h33;
    localparam logic [6:0] OPCODE_J_TYPE = 7'h6F;

    // True for the opcodes this core can execute; anything else faults in DECODE.
    function automatic logic opcode_legal(input logic [6:0] op);
        return (op == OPCODE_I_TYPE) || (op == OPCODE_B_TYPE) ||
               (op == OPCODE_R_TYPE) || (op == OPCODE_J_TYPE);
    endfunction

endpackage

// File: rtl/seq_fetch_timer.sv
// Fetch wait-cycle counter. Counts FETCH cycles without an acknowledge and
// flags the cycle in which the LIMIT-th consecutive unacknowledged cycle occurs.
module seq_fetch_timer #(
    parameter int TO_W  = 4,
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    // Wait counter: clear dominates, otherwise count unacknowledged fetch cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expiry is qualified by i_inc so an acknowledged cycle never reports timeout.
    assign o_expired = i_inc && (r_cnt == TO_W'(LIMIT - 1));

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer around the combinational control
// unit: instruction fetch handshake, IR, write-back gating, run control,
// fault detection and retired-instruction counting.
module cpu_sequencer
    import fib_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int FETCH_TO = 15,
    parameter int TO_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_en,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir_q,
    input  logic             cu_regwrite,
    input  logic             cu_pc_write,
    output logic             rf_we,
    output logic             pc_we,
    output logic             busy,
    output logic             halted,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] retired_cnt
);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [31:0]       r_ir;
    logic [CNT_W-1:0]  r_retired;
    fault_code_t       r_fault_code;
    logic              w_fetch_wait;
    logic              w_to_clr;
    logic              w_to_expired;
    logic              w_opcode_ok;

    assign w_fetch_wait = (r_state == ST_FETCH) && !imem_ack;
    assign w_to_clr     = (w_state_nxt != ST_FETCH);
    assign w_opcode_ok  = opcode_legal(r_ir[6:0]);

    seq_fetch_timer #(
        .TO_W  (TO_W),
        .LIMIT (FETCH_TO)
    ) u_fetch_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (w_to_clr),
        .i_inc     (w_fetch_wait),
        .o_expired (w_to_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; halt is only honoured at instruction boundaries (IDLE/WB).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (halt_req)   w_state_nxt = ST_HALT;
                else if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack)          w_state_nxt = ST_DECODE;
                else if (w_to_expired) w_state_nxt = ST_FAULT;
            end
            ST_DECODE: w_state_nxt = w_opcode_ok ? ST_EXEC : ST_FAULT;
            ST_EXEC:   w_state_nxt = ST_WB;
            ST_WB: begin
                if (halt_req)     w_state_nxt = ST_HALT;
                else if (step_en) w_state_nxt = ST_IDLE;
                else              w_state_nxt = ST_FETCH;
            end
            ST_HALT: begin
                if (start && !halt_req) w_state_nxt = ST_FETCH;
            end
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Instruction register loads only on an acknowledged fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir <= '0;
        end else if ((r_state == ST_FETCH) && imem_ack) begin
            r_ir <= imem_rdata;
        end
    end

    // Retired counter advances once per WB and sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if ((r_state == ST_WB) && (r_retired != '1)) begin
            r_retired <= r_retired + 1'b1;
        end
    end

    // Fault cause is captured on the transition into FAULT and held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault_code <= FC_NONE;
        end else if ((r_state == ST_FETCH) && (w_state_nxt == ST_FAULT)) begin
            r_fault_code <= FC_TIMEOUT;
        end else if ((r_state == ST_DECODE) && (w_state_nxt == ST_FAULT)) begin
            r_fault_code <= FC_ILLEGAL;
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign rf_we       = (r_state == ST_WB) && cu_regwrite;
    assign pc_we       = (r_state == ST_WB) && cu_pc_write;
    assign busy        = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                         (r_state == ST_EXEC)  || (r_state == ST_WB);
    assign halted      = (r_state == ST_HALT);
    assign fault       = (r_state == ST_FAULT);
    assign fault_code  = r_fault_code;
    assign ir_q        = r_ir;
    assign retired_cnt = r_retired;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer. Expected behaviour is derived from
// per-instruction timing arithmetic (fetch waits + 3 fixed phases) and a
// retired-count model; a second instance with a 2-bit counter exercises saturation.
module tb_cpu_sequencer;

    localparam int FETCH_TO = 15;
    localparam int TO_W     = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        step_en;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        cu_regwrite;
    logic        cu_pc_write;

    logic        imem_req, rf_we, pc_we, busy, halted, fault;
    logic [31:0] ir_q;
    logic [1:0]  fault_code;
    logic [31:0] retired_cnt;

    logic        imem_req_2, rf_we_2, pc_we_2, busy_2, halted_2, fault_2;
    logic [31:0] ir_q_2;
    logic [1:0]  fault_code_2;
    logic [1:0]  retired_cnt_2;

    int     checks   = 0;
    int     failures = 0;
    longint exp_retired;
    int     exp_ret2;

    cpu_sequencer #(.CNT_W(32), .FETCH_TO(FETCH_TO), .TO_W(TO_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .step_en(step_en),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_q(ir_q),
        .cu_regwrite(cu_regwrite), .cu_pc_write(cu_pc_write), .rf_we(rf_we), .pc_we(pc_we),
        .busy(busy), .halted(halted), .fault(fault), .fault_code(fault_code),
        .retired_cnt(retired_cnt)
    );

    cpu_sequencer #(.CNT_W(2), .FETCH_TO(FETCH_TO), .TO_W(TO_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .step_en(step_en),
        .imem_req(imem_req_2), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir_q(ir_q_2),
        .cu_regwrite(cu_regwrite), .cu_pc_write(cu_pc_write), .rf_we(rf_we_2), .pc_we(pc_we_2),
        .busy(busy_2), .halted(halted_2), .fault(fault_2), .fault_code(fault_code_2),
        .retired_cnt(retired_cnt_2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] rand_legal();
        logic [6:0] ops [4];
        ops[0] = 7'h13; ops[1] = 7'h63; ops[2] = 7'h33; ops[3] = 7'h6F;
        return {$urandom_range(0, 32'h1FF_FFFF), ops[$urandom_range(0, 3)]};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_en = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; cu_regwrite = 1'b0; cu_pc_write = 1'b0;
        exp_retired = 0; exp_ret2 = 0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // From IDLE or HALT: one start pulse moves the sequencer into FETCH.
    task automatic kick();
        start = 1'b1;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++; $display("FAIL kick_pre_req got=%b exp=0", imem_req);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // One instruction starting in its first FETCH cycle: `delay` unacknowledged
    // cycles, ack, then DECODE, EXEC, WB. Checks every cycle's outputs.
    task automatic drive_instr(input int delay, input logic [31:0] instr,
                               input logic legal, input int halt_at);
        logic       rw, pw;
        logic [3:0] exp_o;
        for (int p = 0; p <= delay + 3; p++) begin
            if (p == halt_at) halt_req = 1'b1;
            imem_ack    = (p == delay) ? 1'b1 : ((p > delay) ? 1'($urandom_range(0, 1)) : 1'b0);
            imem_rdata  = (p == delay) ? instr : $urandom();
            rw          = 1'($urandom_range(0, 1));
            pw          = 1'($urandom_range(0, 1));
            cu_regwrite = rw;
            cu_pc_write = pw;
            start       = 1'($urandom_range(0, 1));
            #1;
            exp_o = {(p <= delay), 1'b1, (p == delay + 3) & rw, (p == delay + 3) & pw};
            checks++;
            if ({imem_req, busy, rf_we, pc_we} !== exp_o) begin
                failures++;
                $display("FAIL instr_phase p=%0d {req,busy,rf_we,pc_we} got=%b exp=%b",
                         p, {imem_req, busy, rf_we, pc_we}, exp_o);
            end
            if (p > delay) begin
                checks++;
                if (ir_q !== instr) begin
                    failures++; $display("FAIL ir_q p=%0d got=%h exp=%h", p, ir_q, instr);
                end
            end
            if (!legal && (p == delay + 1)) begin
                @(negedge clk);
                start = 1'b0; imem_ack = 1'b0; cu_regwrite = 1'b1; cu_pc_write = 1'b1;
                #1;
                checks++;
                if ({imem_req, busy, halted, fault, rf_we, pc_we} !== 6'b000100) begin
                    failures++;
                    $display("FAIL illegal_state got=%b exp=000100",
                             {imem_req, busy, halted, fault, rf_we, pc_we});
                end
                checks++;
                if (fault_code !== 2'd1) begin
                    failures++; $display("FAIL illegal_code got=%0d exp=1", fault_code);
                end
                checks++;
                if (retired_cnt !== exp_retired[31:0]) begin
                    failures++;
                    $display("FAIL illegal_retired got=%0d exp=%0d", retired_cnt, exp_retired);
                end
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        imem_ack = 1'b0;
        if (exp_retired != 64'hFFFF_FFFF) exp_retired++;
        if (exp_ret2 != 3) exp_ret2++;
        checks++;
        if (retired_cnt !== exp_retired[31:0]) begin
            failures++; $display("FAIL retired got=%0d exp=%0d", retired_cnt, exp_retired);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        cu_regwrite = 1'b1; cu_pc_write = 1'b1; halt_req = 1'b0; step_en = 1'b0;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({imem_req, rf_we, pc_we, busy, halted, fault, fault_code} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0",
                     {imem_req, rf_we, pc_we, busy, halted, fault, fault_code});
        end
        checks++;
        if ({ir_q, retired_cnt} !== 64'h0) begin
            failures++; $display("FAIL reset_regs ir=%h ret=%0d exp=0", ir_q, retired_cnt);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({imem_req, busy, halted, fault} !== 4'b0000) begin
            failures++; $display("FAIL idle_hold got=%b exp=0000", {imem_req, busy, halted, fault});
        end
    endtask

    task automatic test_single();
        do_reset();
        step_en = 1'b1;
        kick();
        drive_instr(0, 32'h00100093, 1'b1, -1);
        #1;
        checks++;
        if ({busy, halted, imem_req} !== 3'b000) begin
            failures++; $display("FAIL step_idle got=%b exp=000", {busy, halted, imem_req});
        end
        @(negedge clk); @(negedge clk);
        checks++;
        if ({busy, imem_req, retired_cnt} !== {2'b00, 32'd1}) begin
            failures++; $display("FAIL step_stays busy=%b ret=%0d", busy, retired_cnt);
        end
    endtask

    task automatic test_wait_ack();
        do_reset();
        step_en = 1'b1;
        kick();
        drive_instr(3, 32'h00000063, 1'b1, -1);
        kick();
        drive_instr(FETCH_TO - 1, rand_legal(), 1'b1, -1);
    endtask

    task automatic test_timeout();
        do_reset();
        kick();
        for (int c = 0; c < FETCH_TO; c++) begin
            imem_ack = 1'b0;
            #1;
            checks++;
            if ({imem_req, busy, fault} !== 3'b110) begin
                failures++;
                $display("FAIL to_wait c=%0d got=%b exp=110", c, {imem_req, busy, fault});
            end
            @(negedge clk);
        end
        for (int c = 0; c < 3; c++) begin
            start = 1'b1; imem_ack = 1'b1;
            #1;
            checks++;
            if ({imem_req, busy, fault, fault_code} !== 5'b00110) begin
                failures++;
                $display("FAIL to_fault c=%0d got=%b exp=00110",
                         c, {imem_req, busy, fault, fault_code});
            end
            @(negedge clk);
        end
        start = 1'b0; imem_ack = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        kick();
        drive_instr(0, rand_legal(), 1'b1, -1);
        drive_instr(1, {$urandom_range(0, 32'h1FF_FFFF), 7'h03}, 1'b0, -1);
    endtask

    task automatic test_halt();
        do_reset();
        halt_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({halted, busy} !== 2'b10) begin
            failures++; $display("FAIL halt_idle got=%b exp=10", {halted, busy});
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({halted, imem_req} !== 2'b10) begin
            failures++; $display("FAIL halt_start_held got=%b exp=10", {halted, imem_req});
        end
        halt_req = 1'b0;
        kick();
        drive_instr(2, rand_legal(), 1'b1, 0);
        #1;
        checks++;
        if ({halted, busy, imem_req} !== 3'b100) begin
            failures++; $display("FAIL halt_fetch_raise got=%b exp=100", {halted, busy, imem_req});
        end
        halt_req = 1'b0;
        kick();
        step_en = 1'b1;
        drive_instr(1, rand_legal(), 1'b1, 1 + 2);
        #1;
        checks++;
        if ({halted, busy} !== 2'b10) begin
            failures++; $display("FAIL halt_over_step got=%b exp=10", {halted, busy});
        end
        halt_req = 1'b0; step_en = 1'b0;
        kick();
        drive_instr(0, rand_legal(), 1'b1, -1);
    endtask

    task automatic test_async_reset();
        do_reset();
        kick();
        drive_instr(0, rand_legal(), 1'b1, -1);
        imem_ack = 1'b1; imem_rdata = 32'h00100093;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        cu_regwrite = 1'b1; cu_pc_write = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL exec_busy got=%b exp=1", busy);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, rf_we, pc_we, busy, halted, fault, fault_code, ir_q, retired_cnt} !== '0) begin
            failures++;
            $display("FAIL async_reset ctrl=%b ir=%h ret=%0d exp=0",
                     {imem_req, rf_we, pc_we, busy, halted, fault, fault_code}, ir_q, retired_cnt);
        end
        @(posedge clk); #1;
        checks++;
        if ({rf_we, pc_we, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_no_wb got=%b exp=000", {rf_we, pc_we, busy});
        end
        @(negedge clk);
        rst_n = 1'b1; cu_regwrite = 1'b0; cu_pc_write = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        kick();
        for (int k = 0; k < 5; k++) begin
            drive_instr($urandom_range(0, 2), rand_legal(), 1'b1, -1);
            checks++;
            if (retired_cnt_2 !== 2'(exp_ret2)) begin
                failures++; $display("FAIL sat_retired k=%0d got=%0d exp=%0d", k, retired_cnt_2, exp_ret2);
            end
        end
    endtask

    task automatic test_random();
        int d, h;
        do_reset();
        kick();
        for (int n = 0; n < 30; n++) begin
            d       = $urandom_range(0, FETCH_TO - 1);
            h       = ($urandom_range(0, 3) == 0) ? $urandom_range(0, d + 3) : -1;
            step_en = ($urandom_range(0, 3) == 0);
            drive_instr(d, rand_legal(), 1'b1, h);
            #1;
            if (h >= 0) begin
                checks++;
                if ({halted, busy} !== 2'b10) begin
                    failures++; $display("FAIL rnd_halt n=%0d got=%b exp=10", n, {halted, busy});
                end
                halt_req = 1'b0;
                kick();
            end else if (step_en) begin
                checks++;
                if ({halted, busy} !== 2'b00) begin
                    failures++; $display("FAIL rnd_step n=%0d got=%b exp=00", n, {halted, busy});
                end
                kick();
            end
        end
        step_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; step_en = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; cu_regwrite = 1'b0; cu_pc_write = 1'b0;
        exp_retired = 0; exp_ret2 = 0;
        test_reset();
        test_single();
        test_wait_ack();
        test_timeout();
        test_illegal();
        test_halt();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
